// File: rtl/i2s_rx_if.sv
// i2s_rx_if: output handshake bundle of the I2S receiver.
//   rx_left  : left word at the FIFO head
//   rx_right : right word at the FIFO head
//   rx_valid : head entry holds a stereo pair
//   rx_ready : consumer accepts the head when rx_valid && rx_ready at a clk rise
// master = receiver side (drives data/valid), slave = consumer side (drives ready).
interface i2s_rx_if #(
  parameter int unsigned BIT_DEPTH = 8
) ();
  logic [BIT_DEPTH-1:0] rx_left;
  logic [BIT_DEPTH-1:0] rx_right;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_left,
    output rx_right,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_left,
    input  rx_right,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: I2S (Philips format) slave receiver with a stereo-pair FIFO.
// Oversamples bclk/lrclk/sdata in the clk domain, deserialises MSB-first words,
// pairs left with the following right word and queues pairs for the consumer.
// Ports:
//   clk       : system clock, at least 4x the bclk frequency
//   reset     : asynchronous active-low reset
//   bclk      : I2S bit clock (asynchronous)
//   lrclk     : word select (asynchronous), 0 = left, 1 = right
//   sdata     : serial data, MSB first
//   rx        : output handshake (i2s_rx_if.master)
//   ovf_clr   : clears overflow (and frame_err when built)
//   overflow  : sticky, a pair was dropped on a full FIFO
//   frame_err : sticky framing error
// Optional feature: define I2S_RX_FRAME_CHECK_EN to build the word-length check
// driving frame_err; otherwise frame_err is tied low.
module i2s_rx #(
  parameter int unsigned BIT_DEPTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     bclk,
  input  logic     lrclk,
  input  logic     sdata,
  i2s_rx_if.master rx,
  input  logic     ovf_clr,
  output logic     overflow,
  output logic     frame_err
);

  localparam int unsigned CW   = $clog2(BIT_DEPTH + 1);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;

  // Input synchronisers; bclk carries one extra stage for edge detection.
  logic [2:0] bclk_sync;
  logic [1:0] lrclk_sync;
  logic [1:0] sdata_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
    end else begin
      bclk_sync  <= {bclk_sync[1:0], bclk};
      lrclk_sync <= {lrclk_sync[0], lrclk};
      sdata_sync <= {sdata_sync[0], sdata};
    end
  end

  logic bit_evt;
  logic lr_s;
  logic sd_s;
  assign bit_evt = bclk_sync[1] & ~bclk_sync[2];
  assign lr_s    = lrclk_sync[1];
  assign sd_s    = sdata_sync[1];

  // Deserialiser state
  logic                 started;    // lr_prev holds a real sample
  logic                 edge_seen;  // at least one channel edge since reset
  logic                 lr_prev;
  logic [CW-1:0]        bit_cnt;
  logic [BIT_DEPTH-1:0] shreg;
  logic [BIT_DEPTH-1:0] shreg_set;
  logic                 ch_edge;

  logic                 word_vld;
  logic                 word_ch;
  logic [BIT_DEPTH-1:0] word_q;

  assign ch_edge = bit_evt & started & (lr_s != lr_prev);

  // Shift register with the current bit placed at BIT_DEPTH-1-bit_cnt.
  always_comb begin
    shreg_set = shreg;
    for (int unsigned i = 0; i < BIT_DEPTH; i++) begin
      if (bit_cnt == CW'(BIT_DEPTH - 1 - i)) shreg_set[i] = sd_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started   <= 1'b0;
      edge_seen <= 1'b0;
      lr_prev   <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      word_vld  <= 1'b0;
      word_ch   <= 1'b0;
      word_q    <= '0;
    end else begin
      word_vld <= 1'b0;
      if (bit_evt) begin
        if (!started) begin
          // First event after reset only establishes the channel; no capture.
          started <= 1'b1;
          lr_prev <= lr_s;
          shreg   <= '0;
          bit_cnt <= '0;
        end else if (ch_edge) begin
          // Edge slot is the Philips delay bit: emit the finished word, drop the bit.
          word_vld  <= edge_seen;
          word_ch   <= lr_prev;
          word_q    <= shreg;
          shreg     <= '0;
          bit_cnt   <= '0;
          lr_prev   <= lr_s;
          edge_seen <= 1'b1;
        end else if (bit_cnt < CW'(BIT_DEPTH)) begin
          shreg   <= shreg_set;
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

  // Left/right pairing
  logic                 left_held;
  logic [BIT_DEPTH-1:0] left_hold;
  logic                 push_q;
  logic [BIT_DEPTH-1:0] push_l;
  logic [BIT_DEPTH-1:0] push_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_held <= 1'b0;
      left_hold <= '0;
      push_q    <= 1'b0;
      push_l    <= '0;
      push_r    <= '0;
    end else begin
      push_q <= 1'b0;
      if (word_vld) begin
        if (!word_ch) begin
          left_hold <= word_q;
          left_held <= 1'b1;
        end else if (left_held) begin
          push_q    <= 1'b1;
          push_l    <= left_hold;
          push_r    <= word_q;
          left_held <= 1'b0;
        end
      end
    end
  end

  // Show-ahead pair FIFO
  logic [BIT_DEPTH-1:0] mem_l [FIFO_DEPTH];
  logic [BIT_DEPTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [CNTW-1:0]      count;
  logic                 valid;
  logic                 full;
  logic                 pop;
  logic                 do_push;
  logic                 ovf_set;

  assign valid   = (count != '0);
  assign full    = (count == CNTW'(FIFO_DEPTH));
  assign pop     = valid & rx.rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_q & (~full | pop);
  assign ovf_set = push_q & full & ~pop;

  assign rx.rx_valid = valid;
  assign rx.rx_left  = valid ? mem_l[rptr] : '0;
  assign rx.rx_right = valid ? mem_r[rptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_l[wptr] <= push_l;
      mem_r[wptr] <= push_r;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      if (do_push && !pop)      count <= count + CNTW'(1);
      else if (!do_push && pop) count <= count - CNTW'(1);
      overflow <= ovf_set | (overflow & ~ovf_clr);
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  localparam int unsigned FW = $clog2(BIT_DEPTH + 2);

  // Non-edge bit events since the last edge, saturating one past BIT_DEPTH.
  logic [FW-1:0] frame_cnt;
  logic          ferr_set;

  assign ferr_set = ch_edge & edge_seen & (frame_cnt != FW'(BIT_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      if (ch_edge) begin
        frame_cnt <= '0;
      end else if (bit_evt && started && frame_cnt != FW'(BIT_DEPTH + 1)) begin
        frame_cnt <= frame_cnt + FW'(1);
      end
      frame_err <= ferr_set | (frame_err & ~ovf_clr);
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed bench for i2s_rx (BIT_DEPTH=8, FIFO_DEPTH=4, 50 MHz clk,
// 1 MHz bclk). Expected words are hand-computed constants.
module tb_i2s_rx;

  localparam int unsigned BitDepth  = 8;
  localparam int unsigned FifoDepth = 4;
`ifdef I2S_RX_FRAME_CHECK_EN
  localparam logic FcEn = 1'b1;
`else
  localparam logic FcEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bclk = 1'b0;
  logic lrclk = 1'b1;
  logic sdata = 1'b0;
  logic ovf_clr = 1'b0;
  logic overflow;
  logic frame_err;

  i2s_rx_if #(.BIT_DEPTH(BitDepth)) rx_if ();

  i2s_rx #(
    .BIT_DEPTH (BitDepth),
    .FIFO_DEPTH(FifoDepth)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .rx       (rx_if),
    .ovf_clr  (ovf_clr),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] l2 [6];
  logic [7:0] r2 [6];
  logic [7:0] l3 [5];
  logic [7:0] r3 [5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One bclk period: drive lrclk/sdata while bclk is low, then raise bclk.
  task automatic slot(input logic lr, input logic sd);
    @(negedge clk);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = sd;
    #500;
    bclk = 1'b1;
    #490;
  endtask

  // Word of nbits MSB first; the edge (delay) slot is sent only on a channel change.
  task automatic send_word(input logic ch, input logic [15:0] data, input int nbits);
    if (lrclk != ch) slot(ch, 1'b0);
    for (int i = nbits - 1; i >= 0; i--) slot(ch, data[i]);
  endtask

  task automatic send_frame(input logic [15:0] l, input int nl,
                            input logic [15:0] r, input int nr);
    send_word(1'b0, l, nl);
    send_word(1'b1, r, nr);
  endtask

  // R->L edge that completes the last right word.
  task automatic close_frame();
    slot(1'b0, 1'b0);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] l, input logic [7:0] r);
    int t = 0;
    @(negedge clk);
    while (!rx_if.rx_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({tag, ".valid"}, 32'(rx_if.rx_valid), 32'd1);
    check({tag, ".left"},  32'(rx_if.rx_left),  32'(l));
    check({tag, ".right"}, 32'(rx_if.rx_right), 32'(r));
    rx_if.rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    l2 = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
    r2 = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5};
    l3 = '{8'h81, 8'h92, 8'hA3, 8'hB4, 8'hC5};
    r3 = '{8'h18, 8'h29, 8'h3A, 8'h4B, 8'h5C};
    rx_if.rx_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.valid", 32'(rx_if.rx_valid), 32'd0);
    check("rst.left",  32'(rx_if.rx_left),  32'd0);
    check("rst.right", 32'(rx_if.rx_right), 32'd0);
    check("rst.ovf",   32'(overflow),       32'd0);
    check("rst.ferr",  32'(frame_err),      32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic capture: partial right preamble is discarded, two pairs follow
    repeat (3) slot(1'b1, 1'b1);
    send_frame(16'hA5, 8, 16'h3C, 8);
    send_frame(16'h01, 8, 16'h80, 8);
    close_frame();
    pop_check("t1a", 8'hA5, 8'h3C);
    pop_check("t1b", 8'h01, 8'h80);
    @(negedge clk);
    check("t1.empty", 32'(rx_if.rx_valid), 32'd0);

    // Overflow: 6 pairs into a 4-deep FIFO with no consumer
    for (int i = 0; i < 6; i++) send_frame(16'(l2[i]), 8, 16'(r2[i]), 8);
    close_frame();
    check("t2.ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("t2p%0d", i), l2[i], r2[i]);
    @(negedge clk);
    check("t2.empty", 32'(rx_if.rx_valid), 32'd0);
    pulse_clr();
    check("t2.ovfclr", 32'(overflow), 32'd0);

    // Full FIFO, pair arrives in the same cycle as a pop
    for (int i = 0; i < 4; i++) send_frame(16'(l3[i]), 8, 16'(r3[i]), 8);
    close_frame();
    send_frame(16'(l3[4]), 8, 16'(r3[4]), 8);
    @(negedge clk);
    bclk  = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    #500;
    bclk = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rx_if.rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    check("t3.ovf",   32'(overflow),       32'd0);
    check("t3.valid", 32'(rx_if.rx_valid), 32'd1);
    for (int i = 1; i < 5; i++) pop_check($sformatf("t3p%0d", i), l3[i], r3[i]);
    @(negedge clk);
    check("t3.empty", 32'(rx_if.rx_valid), 32'd0);

    // Reset mid-right-word with a pair already queued
    send_frame(16'h11, 8, 16'h22, 8);
    close_frame();
    send_word(1'b0, 16'h77, 8);
    slot(1'b1, 1'b0);
    slot(1'b1, 1'b1);
    slot(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t5.valid", 32'(rx_if.rx_valid), 32'd0);
    check("t5.left",  32'(rx_if.rx_left),  32'd0);
    reset = 1'b1;
    slot(1'b1, 1'b1);
    slot(1'b1, 1'b1);
    send_frame(16'h5A, 8, 16'hC3, 8);
    close_frame();
    pop_check("t5p", 8'h5A, 8'hC3);
    repeat (3) @(negedge clk);
    check("t5.empty", 32'(rx_if.rx_valid), 32'd0);
    check("t5.ferr",  32'(frame_err),      32'd0);

    // Long word truncated, short word zero-padded
    send_frame(16'h2AB, 10, 16'h2D, 6);
    close_frame();
    pop_check("t4p", 8'hAA, 8'hB4);
    check("t4.ferr", 32'(frame_err), 32'(FcEn));
    pulse_clr();
    check("t4.ferrclr", 32'(frame_err), 32'd0);

    // 7-bit left word: framing error when the check is built
    send_frame(16'h55, 7, 16'h66, 8);
    close_frame();
    pop_check("t6p", 8'hAA, 8'h66);
    check("t6.ferr", 32'(frame_err), 32'(FcEn));
    pulse_clr();
    check("t6.ferrclr", 32'(frame_err), 32'd0);
    check("t6.ovf", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S slave receiver, the capture-side counterpart of the team's I2S transmitter.
- Oversamples externally driven bclk/lrclk/sdata in the single system clock domain and deserialises MSB-first Philips-format stereo words.
- Pairs left and right words and queues them in a small FIFO with a valid/ready output handshake for downstream processing logic.

Parameters:
- BIT_DEPTH, 8, bits per channel word captured and presented.
- FIFO_DEPTH, 4, stereo-pair entries buffered; power of two, >= 2.

Ports:
- clk  in  1  system clock; must be >= 4x bclk frequency.
- reset  in  1  asynchronous, active-low reset.
- bclk  in  1  I2S bit clock, asynchronous to clk.
- lrclk  in  1  word select, asynchronous to clk; 0 = left, 1 = right.
- sdata  in  1  serial data, MSB first.
- rx_left  out  BIT_DEPTH  left word at FIFO head.
- rx_right  out  BIT_DEPTH  right word at FIFO head.
- rx_valid  out  1  FIFO head holds a pair.
- rx_ready  in  1  consumer accepts head when rx_valid && rx_ready at a clk rise.
- ovf_clr  in  1  clears overflow.
- overflow  out  1  sticky: a pair was dropped because the FIFO was full.
- frame_err  out  1  sticky framing error (optional feature).

Behaviour:
- Reset (reset low, asynchronous):
  - Clears synchronisers, shift register, bit count, left-hold and left-held flag, FIFO pointers and count.
  - Outputs: rx_valid=0, rx_left=0, rx_right=0, overflow=0, frame_err=0.
  - Reset mid-word or mid-frame discards all partial data; capture restarts at the next lrclk edge.
- Input sampling:
  - bclk, lrclk, sdata each pass through a 2-flop synchroniser, then one more flop.
  - Bit event = registered bclk rising edge (sync2 & ~sync3). lrclk and sdata are taken from the same stage as bclk.
- On each bit event, with lr_prev equal to the lrclk seen at the previous bit event:
  - lrclk != lr_prev (channel edge):
    - The bit in this slot is the Philips delay slot and is ignored.
    - The completed word for channel lr_prev is emitted.
    - Shift register cleared to 0; bit_cnt=0; lr_prev updated.
  - Otherwise, if bit_cnt < BIT_DEPTH: sdata is written at position BIT_DEPTH-1-bit_cnt, then bit_cnt increments.
  - Bits beyond BIT_DEPTH are ignored (bit_cnt saturates).
  - Short words are zero-padded at the LSBs.
- Word handling:
  - Left word completes: stored in left-hold; left-held flag set.
  - Right word completes with left-held flag set: {left-hold, right} pushed to FIFO; flag cleared.
  - Right word completes with flag clear (first frame after reset): discarded.
  - First edge after reset: no word is emitted.
- FIFO:
  - Show-ahead; rx_left/rx_right are valid whenever rx_valid=1.
  - Pop when rx_valid && rx_ready.
  - Push while full, no pop in the same cycle: pair dropped, overflow set.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push and pop in the same cycle when empty: no pop, push occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow flag: ovf_clr clears overflow; a simultaneous set wins.
- Latency: with the FIFO empty, rx_valid rises at the 4th clk rise after the clk rise that first samples bclk high in the R->L-edge slot.
- Out of scope: no clock generation and no mclk; this block is a pure slave.

Optional Feature:
- Macro: I2S_RX_FRAME_CHECK_EN.
- Defined:
  - At each channel edge, frame_err is set if the number of non-edge bit events since the previous edge != BIT_DEPTH.
  - The first edge after reset is exempt.
  - frame_err is sticky, cleared by ovf_clr; a simultaneous set wins.
  - Words are still emitted normally.
- Undefined: frame_err is tied to 0 and no check logic is built.

Test Plan:
- BIT_DEPTH=8, clk 50 MHz, bclk 1 MHz. Send frames L=0xA5,R=0x3C then L=0x01,R=0x80 -> first R discarded; two pops return (0xA5,0x3C) and (0x01,0x80).
- rx_ready=0, send 6 pairs with FIFO_DEPTH=4 -> 4 pairs held, overflow=1. Pop all -> first 4 pairs returned in order. Pulse ovf_clr -> overflow=0.
- FIFO full, new pair arriving in the cycle rx_ready=1 pops -> no drop, overflow stays 0, count stays 4.
- 10-bit words 0x2AB on 8-bit config -> captured 0xAA. 6-bit words 0x2D -> captured 0xB4.
- Assert reset mid-right-word, release -> rx_valid=0. Next complete L/R frame pair produces exactly one correct pair.
- With I2S_RX_FRAME_CHECK_EN, one 7-bit left word -> frame_err=1 after that edge. ovf_clr -> 0. Without the macro, frame_err stays 0.
